// File: rtl/mem_access_unit_pkg.sv
// Shared configuration for the memory-stage access unit: data width,
// RAM port encodings, RV32I load/store funct3 codes and FSM state type.
package mem_access_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ZERO_32BIT = '0;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [2:0] STORE_B = 3'b001;
  localparam logic [2:0] STORE_H = 3'b010;
  localparam logic [2:0] STORE_W = 3'b100;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } mau_state_e;

  // RAM write_size encoding for a store funct3.
  function automatic logic [2:0] store_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   store_size = STORE_B;
      2'b01:   store_size = STORE_H;
      default: store_size = STORE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data extension: sign- or zero-extends the raw little-endian RAM word
// according to the load funct3. The byte at the access address is in [7:0].
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  // Select the extension mode from funct3.
  always_comb begin
    ext = raw;
    case (funct3)
      LB:      ext = {{24{raw[7]}}, raw[7:0]};
      LBU:     ext = {24'h0, raw[7:0]};
      LH:      ext = {{16{raw[15]}}, raw[15:0]};
      LHU:     ext = {16'h0, raw[15:0]};
      LW:      ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage initiator: accepts one load/store at a time, checks funct3,
// alignment and range, drives the RAM for one issue cycle and returns one
// registered response per request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [15:0] MEM_DEPTH = 16'hffff
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            ram_en,
  output logic            read_flag,
  output logic [XLEN-1:0] read_addr,
  input  logic [XLEN-1:0] read_data,
  output logic            write_flag,
  output logic [XLEN-1:0] write_addr,
  output logic [XLEN-1:0] write_data,
  output logic [2:0]      write_size
);

  mau_state_e state, state_n;

  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_err_q;

  logic [XLEN-1:0] load_word;

  logic [32:0] span;
  logic [32:0] last_byte;
  logic [32:0] mem_last;
  logic        illegal;
  logic        misaligned;
  logic        range_err;
  logic        req_err;

  load_ext u_load_ext (
    .funct3 (funct3_q),
    .raw    (read_data),
    .ext    (load_word)
  );

  // Request error check. 33-bit arithmetic keeps addr+3 near the top of the
  // address space from wrapping back into range; loads always span 4 bytes
  // because the RAM fetches a whole word.
  always_comb begin
    span = 33'd3;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00:   span = 33'd0;
        2'b01:   span = 33'd1;
        default: span = 33'd3;
      endcase
    end
    last_byte = {1'b0, req_addr} + span;
    mem_last  = {1'b0, MEM_BASE} + {17'h0, MEM_DEPTH} - 33'd1;
    range_err = ({1'b0, req_addr} < {1'b0, MEM_BASE}) || (last_byte > mem_last);
    if (req_we) illegal = (req_funct3 >= 3'b011);
    else        illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = illegal || misaligned || range_err;
  end

  // State register, request latch and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rsp_data_q <= '0;
            rsp_err_q  <= req_err;
          end
        end
        S_CAPTURE: rsp_data_q <= load_word;
        S_RESP: begin
          if (rsp_ready) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and state-decoded outputs; RAM outputs only in ISSUE.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_en     = 1'b0;
    read_flag  = 1'b0;
    read_addr  = ZERO_32BIT;
    write_flag = 1'b0;
    write_addr = ZERO_32BIT;
    write_data = ZERO_32BIT;
    write_size = '0;
    case (state)
      S_IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_n = req_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        ram_en = 1'b1;
        if (we_q) begin
          write_flag = WRITE_ENABLE;
          write_addr = addr_q;
          write_data = wdata_q;
          write_size = store_size(funct3_q);
          state_n    = S_RESP;
        end else begin
          read_flag = READ_ENABLE;
          read_addr = addr_q;
          state_n   = S_CAPTURE;
        end
      end
      S_CAPTURE: state_n = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural byte RAM.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        ram_en, read_flag, write_flag;
  logic [31:0] read_addr, read_data, write_addr, write_data;
  logic [2:0]  write_size;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];

  mem_access_unit #(.MEM_BASE(32'h0000_0000), .MEM_DEPTH(16'hffff)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ram_en(ram_en), .read_flag(read_flag),
    .read_addr(read_addr), .read_data(read_data), .write_flag(write_flag),
    .write_addr(write_addr), .write_data(write_data), .write_size(write_size)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, word read valid the cycle after issue.
  always @(posedge clk) begin
    if (ram_en && write_flag) begin
      mem[write_addr[15:0]] <= write_data[7:0];
      if (write_size != STORE_B) mem[write_addr[15:0] + 16'd1] <= write_data[15:8];
      if (write_size == STORE_W) begin
        mem[write_addr[15:0] + 16'd2] <= write_data[23:16];
        mem[write_addr[15:0] + 16'd3] <= write_data[31:24];
      end
    end
    if (ram_en && read_flag)
      read_data <= {mem[read_addr[15:0] + 16'd3], mem[read_addr[15:0] + 16'd2],
                    mem[read_addr[15:0] + 16'd1], mem[read_addr[15:0]]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE with rsp_ready high; returns response and latency.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] d, output logic e,
                         output int lat, output logic ram_seen);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    d = '0; e = 1'b0; ram_seen = 1'b0;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (ram_en) ram_seen = 1'b1;
      step();
      lat++;
    end
    tests++;
    if (!rsp_valid) begin
      fails++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
    end else begin
      d = rsp_data;
      e = rsp_err;
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    tests++; if (ram_en !== 1'b0) begin fails++; $display("FAIL reset_ram_en: got %b required 0", ram_en); end
    tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
    rst_n = 1'b1;
    step();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_sw_lw();
    logic [31:0] d; logic e; int lat; logic rs;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h10; req_wdata = 32'h8765_4321;
    step();
    req_valid = 1'b0;
    tests++; if (write_size !== STORE_W) begin fails++; $display("FAIL sw_size: got %b required %b", write_size, STORE_W); end
    tests++; if ({ram_en, write_flag, read_flag} !== 3'b110) begin fails++; $display("FAIL sw_flags: got %b required 110", {ram_en, write_flag, read_flag}); end
    tests++; if (write_addr !== 32'h10) begin fails++; $display("FAIL sw_addr: got %h required 10", write_addr); end
    tests++; if (write_data !== 32'h8765_4321) begin fails++; $display("FAIL sw_data: got %h required 87654321", write_data); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sw_busy: got %b required 0", req_ready); end
    step();
    tests++; if ({rsp_valid, rsp_err, ram_en} !== 3'b100) begin fails++; $display("FAIL sw_rsp: got %b required 100", {rsp_valid, rsp_err, ram_en}); end
    tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL sw_rsp_data: got %h required 0", rsp_data); end
    step();
    tests++; if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL sw_idle: got %b required 01", {rsp_valid, req_ready}); end
    run_req(1'b0, LW, 32'h10, 32'h0, d, e, lat, rs);
    tests++; if (lat !== 3) begin fails++; $display("FAIL lw_latency: got %0d required 3", lat); end
    tests++; if (d !== 32'h8765_4321) begin fails++; $display("FAIL lw_data: got %h required 87654321", d); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL lw_err: got %b required 0", e); end
  endtask

  task automatic test_byte_half();
    logic [31:0] d; logic e; int lat; logic rs;
    run_req(1'b1, SB, 32'h21, 32'h1234_56F0, d, e, lat, rs);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sb_latency: got %0d required 2", lat); end
    run_req(1'b0, LB, 32'h21, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL lb_data: got %h required fffffff0", d); end
    run_req(1'b0, LBU, 32'h21, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'h0000_00F0) begin fails++; $display("FAIL lbu_data: got %h required 000000f0", d); end
    run_req(1'b1, SH, 32'h30, 32'hABCD_8001, d, e, lat, rs);
    run_req(1'b0, LH, 32'h30, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_data: got %h required ffff8001", d); end
    run_req(1'b0, LHU, 32'h30, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'h0000_8001) begin fails++; $display("FAIL lhu_data: got %h required 00008001", d); end
    run_req(1'b0, LW, 32'h20, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'h0000_F000) begin fails++; $display("FAIL lw_around_sb: got %h required 0000f000", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat; logic rs;
    logic        v_we   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  v_f3   [9] = '{LW, SH, 3'b011, 3'b011, 3'b110, LW, SW, LW, SB};
    logic [31:0] v_addr [9] = '{32'h13, 32'h31, 32'h40, 32'h40, 32'h40, 32'hFFFC,
                                32'hFFFC, 32'hFFFF_FFFC, 32'hFFFE};
    logic        v_err  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_req(v_we[i], v_f3[i], v_addr[i], 32'h5555_AAAA, d, e, lat, rs);
      tests++; if (e !== v_err[i]) begin fails++; $display("FAIL err_flag[%0d]: got %b required %b", i, e, v_err[i]); end
      if (v_err[i]) begin
        tests++; if ({lat == 1, rs, d == 32'h0} !== 3'b101) begin fails++;
          $display("FAIL err_resp[%0d]: latency=%0d ram_en_seen=%b data=%h required latency=1 ram_en_seen=0 data=0", i, lat, rs, d); end
      end else begin
        tests++; if ({lat == 2, rs} !== 2'b11) begin fails++;
          $display("FAIL top_byte_store[%0d]: latency=%0d ram_en_seen=%b required 2 and 1", i, lat, rs); end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LB; req_addr = 32'hFFFE; req_wdata = '0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if ({rsp_valid, rsp_err, req_ready, ram_en} !== 4'b1100) begin fails++;
        $display("FAIL hold[%0d]: valid/err/ready/ram_en got %b required 1100", i, {rsp_valid, rsp_err, req_ready, ram_en}); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    tests++; if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin fails++;
      $display("FAIL hold_release: valid/err/ready got %b required 001", {rsp_valid, rsp_err, req_ready}); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h10; req_wdata = '0;
    step();
    req_valid = 1'b0;
    tests++; if ({ram_en, read_flag, read_addr} !== {2'b11, 32'h10}) begin fails++;
      $display("FAIL lw_issue: ram_en/read_flag/read_addr got %b%b/%h required 11/00000010", ram_en, read_flag, read_addr); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b required 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      step();
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL mid_reset_no_rsp: rsp_valid cycles got %0d required 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat; logic rs;
    run_req(1'b1, SW, 32'h40, 32'hDEAD_BEEF, d, e, lat, rs);
    tests++; if ({lat == 2, e} !== 2'b10) begin fails++; $display("FAIL b2b_sw: latency=%0d err=%b required 2 and 0", lat, e); end
    run_req(1'b0, LW, 32'h40, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_lw: got %h required deadbeef", d); end
    run_req(1'b0, LH, 32'h42, 32'h0, d, e, lat, rs);
    tests++; if (d !== 32'hFFFF_DEAD) begin fails++; $display("FAIL b2b_lh_upper: got %h required ffffdead", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    read_data = '0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_sw_lw();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
